// File: rtl/sha256_pkg.sv
// Shared constants for the SHA-256 message-schedule controller.
package sha256_pkg;

    // Default word width, rounds per block and shift-step timeout.
    localparam int unsigned N_DEF      = 32;
    localparam int unsigned ROUNDS_DEF = 64;
    localparam int unsigned TMO_DEF    = 15;

    // Round index width; a block never exceeds 64 rounds.
    localparam int unsigned RW = 6;

    // Controller states, one-hot encoded.
    localparam int unsigned ST_W = 6;
    localparam logic [ST_W-1:0] ST_IDLE  = 6'b000001;
    localparam logic [ST_W-1:0] ST_LOAD  = 6'b000010;
    localparam logic [ST_W-1:0] ST_EMIT  = 6'b000100;
    localparam logic [ST_W-1:0] ST_SHIFT = 6'b001000;
    localparam logic [ST_W-1:0] ST_DONE  = 6'b010000;
    localparam logic [ST_W-1:0] ST_ERR   = 6'b100000;

endpackage

// File: rtl/round_cnt.sv
// 6-bit round counter with synchronous clear and count enable.
module round_cnt
    import sha256_pkg::*;
(
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          clr,
    input  logic          en,
    output logic [RW-1:0] cnt
);

    // Clear wins over enable; the controller never enables past the last round.
    always_ff @(posedge clk_i) begin
        if (rst_i || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + RW'(1);
        end
    end

endmodule

// File: rtl/msg_sched_ctrl.sv
// Message-schedule controller: loads the extender window, hands W_t words
// to the compression core and steps the extender between rounds.
module msg_sched_ctrl
    import sha256_pkg::*;
#(
    parameter int unsigned N      = N_DEF,
    parameter int unsigned ROUNDS = ROUNDS_DEF,
    parameter int unsigned TMO    = TMO_DEF
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          start_i,
    output logic          load_o,
    output logic          ena_shift_o,
    input  logic          fl_end_i,
    input  logic [N-1:0]  w0_i,
    output logic [N-1:0]  wt_o,
    output logic          wt_valid_o,
    input  logic          wt_ready_i,
    output logic [RW-1:0] round_o,
    output logic          busy_o,
    output logic          done_o,
    output logic          err_o
);

    // Timeout counter only has to hold 0..TMO-1.
    localparam int unsigned TW = (TMO < 2) ? 1 : $clog2(TMO);
    localparam logic [TW-1:0] TMO_LAST = TW'(TMO - 1);
    localparam logic [RW-1:0] T_LAST   = RW'(ROUNDS - 1);

    logic [ST_W-1:0] state;
    logic [ST_W-1:0] state_nxt;
    logic [TW-1:0]   tmo_cnt;
    logic [TW-1:0]   tmo_nxt;
    logic [RW-1:0]   t;
    logic            t_clr;
    logic            t_en;

    // Round index t: cleared on load, bumped when a non-final word is accepted.
    round_cnt u_round_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr   (t_clr),
        .en    (t_en),
        .cnt   (t)
    );

    // Next-state, round-counter control and shift-timeout accounting.
    always_comb begin
        state_nxt = state;
        tmo_nxt   = tmo_cnt;
        t_clr     = 1'b0;
        t_en      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_i) begin
                    state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                t_clr     = 1'b1;
                state_nxt = ST_EMIT;
            end
            ST_EMIT: begin
                if (wt_ready_i) begin
                    tmo_nxt = '0;
                    if (t == T_LAST) begin
                        state_nxt = ST_DONE;
                    end else begin
                        t_en      = 1'b1;
                        state_nxt = ST_SHIFT;
                    end
                end
            end
            ST_SHIFT: begin
                // A step finishing on the last allowed cycle still succeeds.
                if (fl_end_i) begin
                    state_nxt = ST_EMIT;
                end else if (tmo_cnt == TMO_LAST) begin
                    state_nxt = ST_ERR;
                end else begin
                    tmo_nxt = tmo_cnt + TW'(1);
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            ST_ERR: begin
                state_nxt = ST_ERR;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, timeout counter and control outputs registered from next state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= ST_IDLE;
            tmo_cnt     <= '0;
            load_o      <= 1'b0;
            ena_shift_o <= 1'b0;
            wt_valid_o  <= 1'b0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            err_o       <= 1'b0;
        end else begin
            state       <= state_nxt;
            tmo_cnt     <= tmo_nxt;
            load_o      <= (state_nxt == ST_LOAD);
            ena_shift_o <= (state_nxt == ST_SHIFT);
            wt_valid_o  <= (state_nxt == ST_EMIT);
            busy_o      <= (state_nxt != ST_IDLE);
            done_o      <= (state_nxt == ST_DONE);
            err_o       <= (state_nxt == ST_ERR);
        end
    end

    // Window head passes straight through while a word is offered, else zero.
    assign wt_o    = wt_valid_o ? w0_i : '0;
    assign round_o = t;

endmodule

// File: tb/tb_msg_sched_ctrl.sv
// Scoreboard bench for msg_sched_ctrl with a behavioural extender model.
module tb_msg_sched_ctrl;

    localparam int unsigned N      = 32;
    localparam int unsigned ROUNDS = 64;
    localparam int unsigned TMO    = 15;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          start_i;
    logic          load_o;
    logic          ena_shift_o;
    logic          fl_end_i;
    logic [N-1:0]  w0_i;
    logic [N-1:0]  wt_o;
    logic          wt_valid_o;
    logic          wt_ready_i;
    logic [5:0]    round_o;
    logic          busy_o;
    logic          done_o;
    logic          err_o;

    msg_sched_ctrl #(.N(N), .ROUNDS(ROUNDS), .TMO(TMO)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .load_o      (load_o),
        .ena_shift_o (ena_shift_o),
        .fl_end_i    (fl_end_i),
        .w0_i        (w0_i),
        .wt_o        (wt_o),
        .wt_valid_o  (wt_valid_o),
        .wt_ready_i  (wt_ready_i),
        .round_o     (round_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .err_o       (err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [5:0]   rnd;
        logic [N-1:0] word;
    } exp_t;

    int checks = 0;
    int errors = 0;

    exp_t         exp_q[$];
    logic [N-1:0] seed_q[$];
    logic [N-1:0] win;

    // Stimulus knobs shared with the driver process.
    int ready_mode     = 0;   // 0: always ready, 1: random, 2: stall at round 10
    int stall_left     = 0;
    int fl_delay       = 2;   // cycles after ena_shift_o rise before fl_end_i
    int withhold_round = -1;  // never finish the step while round_o shows this
    bit stray_fl       = 1'b0;
    int age            = 0;

    // Monitor state.
    bit           prev_hold  = 1'b0;
    bit           exp_done   = 1'b0;
    logic [5:0]   prev_r;
    logic [N-1:0] prev_word;
    int           run        = 0;
    int           last_run   = 0;
    int           loads      = 0;
    int           stall_seen = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Extender's word recurrence; the bench's stand-in for sigma arithmetic.
    function automatic logic [N-1:0] step_word(input logic [N-1:0] w);
        return (w * 32'h9E3779B1) ^ (w >> 7) ^ 32'h5A5A0F0F;
    endfunction

    // Expected block: word t is the seed advanced t times.
    task automatic queue_block(input logic [N-1:0] s);
        logic [N-1:0] w;
        seed_q.push_back(s);
        w = s;
        for (int r = 0; r < int'(ROUNDS); r++) begin
            exp_q.push_back('{rnd: 6'(r), word: w});
            w = step_word(w);
        end
    endtask

    // Extender window: loads a seed on load_o, steps only when it was asked to.
    always @(posedge clk_i) begin
        if (rst_i) begin
            win <= '0;
        end else if (load_o) begin
            chk("load_has_seed", 64'(seed_q.size() > 0), 64'(1));
            if (seed_q.size() > 0) win <= seed_q.pop_front();
        end else if (fl_end_i && ena_shift_o) begin
            win <= step_word(win);
        end
    end
    assign w0_i = win;

    // Extender handshake and core ready, driven just after each rising edge.
    always @(posedge clk_i) begin
        #1;
        if (ena_shift_o) begin
            fl_end_i = !((withhold_round >= 0) && (int'(round_o) == withhold_round))
                       && (age == fl_delay);
            age++;
        end else begin
            age = 0;
            fl_end_i = stray_fl ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        case (ready_mode)
            1: wt_ready_i = ($urandom_range(0, 2) != 0);
            2: begin
                if (wt_valid_o && round_o == 6'd10 && stall_left > 0) begin
                    wt_ready_i = 1'b0;
                    stall_left--;
                end else begin
                    wt_ready_i = 1'b1;
                end
            end
            default: wt_ready_i = 1'b1;
        endcase
    end

    // Monitor: pops the scoreboard on every handshake and checks protocol rules.
    always @(negedge clk_i) begin
        if (rst_i) begin
            prev_hold = 1'b0;
            exp_done  = 1'b0;
            run       = 0;
        end else begin
            exp_t e;
            chk("load_ena_excl", 64'(load_o & ena_shift_o), 64'(0));
            chk("ena_during_emit", 64'(ena_shift_o & wt_valid_o), 64'(0));
            if (load_o) loads++;
            if (prev_hold) begin
                chk("hold_valid", 64'(wt_valid_o), 64'(1));
                chk("hold_round", 64'(round_o), 64'(prev_r));
                chk("hold_word", 64'(wt_o), 64'(prev_word));
            end
            if (wt_valid_o && !wt_ready_i && round_o == 6'd10) stall_seen++;
            if (exp_done || done_o) chk("done_pulse", 64'(done_o), 64'(exp_done));
            exp_done = 1'b0;
            if (wt_valid_o && wt_ready_i) begin
                chk("word_pending", 64'(exp_q.size() > 0), 64'(1));
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("round", 64'(round_o), 64'(e.rnd));
                    chk("word", 64'(wt_o), 64'(e.word));
                    exp_done = (int'(e.rnd) == int'(ROUNDS) - 1);
                end
            end
            prev_hold = wt_valid_o && !wt_ready_i;
            prev_r    = round_o;
            prev_word = wt_o;
            if (ena_shift_o) begin
                run++;
                chk("shift_len", 64'(run <= int'(TMO)), 64'(1));
            end else begin
                if (run > 0) last_run = run;
                run = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #2;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_busy"}, 64'(busy_o), 64'(0));
        chk({tag, "_load"}, 64'(load_o), 64'(0));
        chk({tag, "_ena"}, 64'(ena_shift_o), 64'(0));
        chk({tag, "_valid"}, 64'(wt_valid_o), 64'(0));
        chk({tag, "_done"}, 64'(done_o), 64'(0));
        chk({tag, "_err"}, 64'(err_o), 64'(0));
        chk({tag, "_round"}, 64'(round_o), 64'(0));
        chk({tag, "_wt"}, 64'(wt_o), 64'(0));
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        start_i = 1'b0;
        exp_q.delete();
        seed_q.delete();
        tick();
        rst_i = 1'b0;
    endtask

    // One block from a start pulse; optionally pokes start_i while words are offered.
    task automatic run_block(input bit poke, input int budget,
                             output int first_v, output int first_r, output int done_at);
        queue_block($urandom);
        start_i = 1'b1;
        first_v = -1;
        first_r = -1;
        done_at = -1;
        for (int c = 1; c <= budget; c++) begin
            tick();
            start_i = poke && wt_valid_o && ($urandom_range(0, 1) == 1);
            if (wt_valid_o && first_v < 0) begin
                first_v = c;
                first_r = int'(round_o);
            end
            if (done_o) begin
                done_at = c;
                break;
            end
        end
        start_i = 1'b0;
        chk("block_done_seen", 64'(done_at > 0), 64'(1));
    endtask

    initial begin
        int fv, fr, da, l0, dc, lc, d2, ec;
        int nominal_done;
        nominal_done = 2 + (int'(ROUNDS) - 1) * 4 + 1;
        rst_i = 1'b1;
        start_i = 1'b0;
        fl_end_i = 1'b0;
        wt_ready_i = 1'b1;
        tick();
        do_reset();
        check_idle("reset");

        // Nominal block: ready held, step finishes 2 cycles after ena rise.
        l0 = loads;
        run_block(1'b0, 600, fv, fr, da);
        chk("nom_first_valid_lat", 64'(fv), 64'(2));
        chk("nom_first_round", 64'(fr), 64'(0));
        chk("nom_done_cycle", 64'(da), 64'(nominal_done));
        tick();
        chk("nom_loads", 64'(loads - l0), 64'(1));
        chk("nom_queue_empty", 64'(exp_q.size()), 64'(0));
        chk("nom_idle_busy", 64'(busy_o), 64'(0));

        // Ready stalls for 5 cycles on round 10.
        ready_mode = 2;
        stall_left = 5;
        stall_seen = 0;
        run_block(1'b0, 600, fv, fr, da);
        chk("stall_cycles", 64'(stall_seen), 64'(5));
        chk("stall_done_cycle", 64'(da), 64'(nominal_done + 5));
        tick();

        // Randomised ready and step delay, start poked mid-block, stray fl_end_i.
        ready_mode = 1;
        stray_fl = 1'b1;
        for (int b = 0; b < 3; b++) begin
            fl_delay = (b == 0) ? int'($urandom_range(0, TMO - 1)) : ((b == 1) ? int'(TMO) - 1 : 0);
            l0 = loads;
            run_block(1'b1, 4000, fv, fr, da);
            tick();
            chk("rnd_loads", 64'(loads - l0), 64'(1));
            chk("rnd_queue_empty", 64'(exp_q.size()), 64'(0));
            l0 = loads;
            for (int i = 0; i < 8; i++) begin
                tick();
                chk("stray_fl_idle", 64'(busy_o), 64'(0));
            end
            chk("stray_fl_no_load", 64'(loads - l0), 64'(0));
        end
        stray_fl = 1'b0;
        ready_mode = 0;

        // start_i held high across two blocks.
        fl_delay = 1;
        queue_block($urandom);
        queue_block($urandom);
        l0 = loads;
        dc = -1;
        lc = -1;
        d2 = -1;
        start_i = 1'b1;
        for (int c = 1; c <= 2000; c++) begin
            tick();
            if (dc < 0) begin
                if (done_o) dc = c;
            end else if (lc < 0) begin
                if (load_o) begin
                    lc = c;
                    start_i = 1'b0;
                end
            end else if (done_o) begin
                d2 = c;
                break;
            end
        end
        start_i = 1'b0;
        chk("b2b_load_gap", 64'(lc - dc), 64'(2));
        chk("b2b_second_done", 64'(d2 > 0), 64'(1));
        tick();
        chk("b2b_loads", 64'(loads - l0), 64'(2));
        chk("b2b_queue_empty", 64'(exp_q.size()), 64'(0));

        // Step after round 20 never completes: timeout into ERR.
        fl_delay = 2;
        withhold_round = 21;
        queue_block($urandom);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        ec = -1;
        for (int c = 0; c < 600; c++) begin
            if (err_o) begin
                ec = c;
                break;
            end
            tick();
        end
        chk("tmo_err_seen", 64'(ec >= 0), 64'(1));
        tick();
        chk("tmo_shift_cycles", 64'(last_run), 64'(TMO));
        chk("tmo_words_left", 64'(exp_q.size()), 64'(ROUNDS - 21));
        chk("tmo_err", 64'(err_o), 64'(1));
        chk("tmo_busy", 64'(busy_o), 64'(1));
        chk("tmo_strobes", 64'({load_o, ena_shift_o, wt_valid_o, done_o}), 64'(0));
        l0 = loads;
        start_i = 1'b1;
        repeat (4) tick();
        start_i = 1'b0;
        tick();
        chk("err_start_ignored", 64'(loads - l0), 64'(0));
        chk("err_sticky", 64'(err_o), 64'(1));
        withhold_round = -1;
        do_reset();
        check_idle("err_reset");

        // Reset while round 30 is on offer, then a fresh block.
        queue_block($urandom);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        ec = -1;
        for (int c = 0; c < 400; c++) begin
            if (wt_valid_o && round_o == 6'd30) begin
                ec = c;
                break;
            end
            tick();
        end
        chk("mid_round30_seen", 64'(ec >= 0), 64'(1));
        do_reset();
        check_idle("mid_reset");
        run_block(1'b0, 600, fv, fr, da);
        chk("restart_first_round", 64'(fr), 64'(0));
        chk("restart_first_valid_lat", 64'(fv), 64'(2));
        chk("restart_done_cycle", 64'(da), 64'(nominal_done));
        repeat (2) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard stop if a wait above ever runs away.
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/msg_sched_ctrl.md
MSG_SCHED_CTRL -- requirements
Module: msg_sched_ctrl

Interface
REQ-001 Parameter N, default 32: word width of schedule words.
REQ-002 Parameter ROUNDS, default 64: W_t words emitted per message block.
REQ-003 Parameter TMO, default 15: max cycles allowed from ena_shift_o rise to fl_end_i.
REQ-004 Port clk_i  in  1  the only clock, rising edge.
REQ-005 Port rst_i  in  1  reset, synchronous, active-high.
REQ-006 Port start_i  in  1  begin one 512-bit block; sampled only in IDLE.
REQ-007 Port load_o  out  1  one-cycle load strobe to the extender window (m_i -> window).
REQ-008 Port ena_shift_o  out  1  held high to run one extender add/shift step.
REQ-009 Port fl_end_i  in  1  one-cycle pulse from extender: step complete, window shifted.
REQ-010 Port w0_i  in  N  extender window head (w[0]), the current W_t.
REQ-011 Port wt_o  out  N  W_t to compression core.
REQ-012 Port wt_valid_o  out  1  wt_o valid.
REQ-013 Port wt_ready_i  in  1  compression core accepts wt_o.
REQ-014 Port round_o  out  6  index t of wt_o.
REQ-015 Port busy_o  out  1  high in any state except IDLE.
REQ-016 Port done_o  out  1  one-cycle pulse after round ROUNDS-1 accepted.
REQ-017 Port err_o  out  1  sticky timeout flag, cleared only by reset.

Function
REQ-018 States: IDLE, LOAD, EMIT, SHIFT, DONE, ERR; encoded one-hot.
REQ-019 IDLE: start_i=1 -> LOAD; else stay; start_i ignored in every other state.
REQ-020 LOAD: load_o=1 for exactly one cycle, t cleared to 0, -> EMIT.
REQ-021 EMIT: wt_valid_o=1, wt_o=w0_i, round_o=t; wt_o stable while valid and not ready.
REQ-022 EMIT with wt_valid_o & wt_ready_i: t<ROUNDS-1 -> SHIFT, t incremented; t=ROUNDS-1 -> DONE.
REQ-023 SHIFT: ena_shift_o=1, timeout counter increments each cycle; fl_end_i=1 -> EMIT next cycle, ena_shift_o low in that cycle.
REQ-024 Counter reaching TMO without fl_end_i in SHIFT -> ERR; fl_end_i on the TMO cycle counts as success.
REQ-025 fl_end_i outside SHIFT ignored.
REQ-026 DONE: done_o=1 one cycle -> IDLE; back-to-back start_i in IDLE next cycle accepted.
REQ-027 ERR: all strobes low, err_o=1, busy_o=1; exit only by rst_i.
REQ-028 Minimum latency start_i -> first wt_valid_o: 2 cycles (IDLE->LOAD->EMIT).
REQ-029 t counter width 6 bits, no wrap inside a block; ROUNDS <= 64.
REQ-030 load_o and ena_shift_o never high in the same cycle.

Reset
REQ-031 rst_i=1 at a clock edge -> IDLE, t=0, timeout counter=0, err_o=0, all other outputs 0, including mid-block and in ERR.
REQ-032 rst_i dominates start_i, wt_ready_i, fl_end_i in the same cycle.

Structure
REQ-033 State enum and default constants (N, ROUNDS, TMO) in shared package sha256_pkg.
REQ-034 One sub-module: round_cnt, a 6-bit synchronous counter with clear and enable.
REQ-035 wt_o driven combinationally from w0_i; all control outputs registered.

Verification
REQ-036 start_i, ready held 1, fl_end_i 2 cycles after each ena_shift_o rise -> 64 valid words with round_o 0..63, done_o at cycle 2+63*4+1, load_o exactly once.
REQ-037 Ready low 5 cycles at t=10 -> wt_o/round_o=10 held 5 cycles, no ena_shift_o during stall.
REQ-038 fl_end_i withheld at t=20 -> ERR after 15 SHIFT cycles, err_o=1, later start_i ignored until rst_i.
REQ-039 rst_i at t=30 -> next cycle busy_o=0, outputs 0; new start_i restarts at round_o=0.
REQ-040 start_i pulsed during EMIT and fl_end_i pulsed in IDLE -> no state change, no extra load_o.
REQ-041 start_i high continuously -> second block's load_o one cycle after done_o returns FSM to IDLE.
